// File: rtl/stall_ctrl_if.sv
// Pipeline hazard/stall interface between the decode-side pipeline and stall_ctrl.
interface stall_ctrl_if;
  logic [4:0]  d_rs_addr;
  logic [4:0]  d_rt_addr;
  logic [1:0]  d_rs_tuse;
  logic [1:0]  d_rt_tuse;
  logic [4:0]  e_wa;
  logic [4:0]  m_wa;
  logic [1:0]  e_tnew;
  logic [1:0]  m_tnew;
  logic        d_md_op;
  logic [1:0]  e_md_start;
  logic        cnt_clr;
  logic        block;
  logic        fd_en;
  logic        de_clr;
  logic        md_busy;
  logic        md_err;
  logic [15:0] stall_cnt;

  // Pipeline side: supplies stage information, consumes stall controls.
  modport master (
    output d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse,
    output e_wa, m_wa, e_tnew, m_tnew,
    output d_md_op, e_md_start, cnt_clr,
    input  block, fd_en, de_clr, md_busy, md_err, stall_cnt
  );

  // Stall controller side.
  modport slave (
    input  d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse,
    input  e_wa, m_wa, e_tnew, m_tnew,
    input  d_md_op, e_md_start, cnt_clr,
    output block, fd_en, de_clr, md_busy, md_err, stall_cnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// Decode-stage stall controller: data-hazard detection, mult/div busy tracking
// and a saturating stalled-cycle counter.
module stall_ctrl (
  input  logic         clk,
  input  logic         reset,
  stall_ctrl_if.slave  bus
);

  localparam int unsigned AW = 5;
  localparam int unsigned TW = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY_MUL = 2'd1;
  localparam logic [1:0] ST_BUSY_DIV = 2'd2;

  localparam logic [CW-1:0] MUL_CYCLES = CW'(5);
  localparam logic [CW-1:0] DIV_CYCLES = CW'(10);
  localparam logic [SW-1:0] CNT_MAX    = {SW{1'b1}};
  localparam logic [TW-1:0] TUSE_NONE  = {TW{1'b1}};

  localparam logic [1:0] START_MUL = 2'b01;
  localparam logic [1:0] START_DIV = 2'b10;
  localparam logic [1:0] START_BAD = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          md_err_q, md_err_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;

  logic stall_rs_c, stall_rt_c, stall_md_c, stall_c, md_busy_c;

  // A source stalls when a younger-stage producer cannot forward in time.
  function automatic logic src_hazard(
    input logic [AW-1:0] addr,
    input logic [TW-1:0] tuse,
    input logic [AW-1:0] e_wa,
    input logic [TW-1:0] e_tnew,
    input logic [AW-1:0] m_wa,
    input logic [TW-1:0] m_tnew
  );
    src_hazard = (addr != '0) && (tuse != TUSE_NONE) &&
                 (((e_wa == addr) && (e_tnew > tuse)) ||
                  ((m_wa == addr) && (m_tnew > tuse)));
  endfunction

  assign md_busy_c = (state_q != ST_IDLE);

  // Combinational stall decision, no registered latency.
  always_comb begin
    stall_rs_c = src_hazard(bus.d_rs_addr, bus.d_rs_tuse, bus.e_wa, bus.e_tnew,
                            bus.m_wa, bus.m_tnew);
    stall_rt_c = src_hazard(bus.d_rt_addr, bus.d_rt_tuse, bus.e_wa, bus.e_tnew,
                            bus.m_wa, bus.m_tnew);
    stall_md_c = bus.d_md_op && (md_busy_c || (bus.e_md_start != 2'b00));
    stall_c    = stall_rs_c || stall_rt_c || stall_md_c;
  end

  // Next-state for the mult/div tracker, sticky error and stall counter.
  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    md_err_d    = md_err_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_IDLE: begin
        case (bus.e_md_start)
          START_MUL: begin
            state_d  = ST_BUSY_MUL;
            md_cnt_d = MUL_CYCLES;
          end
          START_DIV: begin
            state_d  = ST_BUSY_DIV;
            md_cnt_d = DIV_CYCLES;
          end
          START_BAD: md_err_d = 1'b1;
          default:   ;
        endcase
      end
      ST_BUSY_MUL, ST_BUSY_DIV: begin
        // A new start while busy is dropped but flagged.
        if (bus.e_md_start != 2'b00) begin
          md_err_d = 1'b1;
        end
        if (md_cnt_q <= CW'(1)) begin
          state_d  = ST_IDLE;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - CW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        md_cnt_d = '0;
      end
    endcase

    // Clear has priority over counting; count saturates at all-ones.
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      md_cnt_q    <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.block     = stall_c;
  assign bus.fd_en     = ~stall_c;
  assign bus.de_clr    = stall_c;
  assign bus.md_busy   = md_busy_c;
  assign bus.md_err    = md_err_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: hazard vector table, directed mult/div
// and counter sequences, then randomized traffic against a cycle-count model.
module tb_stall_ctrl;

  logic clk;
  logic reset;

  stall_ctrl_if bif ();

  stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int rs, rs_tuse, rt, rt_tuse, ewa, etnew, mwa, mtnew;
    int exp_stall;
  } vec_t;

  vec_t vecs[10];

  // Model state: busy cycles still to run, sticky error, stalled-cycle count.
  int m_busy_left;
  int m_err;
  int m_cnt;

  function automatic int hz(input int a, input int tu, input int ew, input int et,
                            input int mw, input int mt);
    if (a == 0 || tu == 3) return 0;
    if (ew == a && et > tu) return 1;
    if (mw == a && mt > tu) return 1;
    return 0;
  endfunction

  function automatic int model_stall();
    int s;
    s = hz(int'(bif.d_rs_addr), int'(bif.d_rs_tuse), int'(bif.e_wa), int'(bif.e_tnew),
           int'(bif.m_wa), int'(bif.m_tnew)) |
        hz(int'(bif.d_rt_addr), int'(bif.d_rt_tuse), int'(bif.e_wa), int'(bif.e_tnew),
           int'(bif.m_wa), int'(bif.m_tnew));
    if (bif.d_md_op && (m_busy_left > 0 || bif.e_md_start != 2'b00)) s = 1;
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int st, s;
    st = int'(bif.e_md_start);
    s  = model_stall();
    if (!reset) begin
      m_busy_left = 0;
      m_err       = 0;
      m_cnt       = 0;
    end else begin
      if (m_busy_left > 0) begin
        if (st != 0) m_err = 1;
        m_busy_left--;
      end else if (st == 1) begin
        m_busy_left = 5;
      end else if (st == 2) begin
        m_busy_left = 10;
      end else if (st == 3) begin
        m_err = 1;
      end
      if (bif.cnt_clr) m_cnt = 0;
      else if (s != 0 && m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic idle_inputs();
    bif.d_rs_addr  = '0;
    bif.d_rt_addr  = '0;
    bif.d_rs_tuse  = 2'd3;
    bif.d_rt_tuse  = 2'd3;
    bif.e_wa       = '0;
    bif.m_wa       = '0;
    bif.e_tnew     = '0;
    bif.m_tnew     = '0;
    bif.d_md_op    = 1'b0;
    bif.e_md_start = 2'b00;
    bif.cnt_clr    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_stall(input string name, input int exp);
    chk({name, "_block"},  int'(bif.block),  exp);
    chk({name, "_fd_en"},  int'(bif.fd_en),  1 - exp);
    chk({name, "_de_clr"}, int'(bif.de_clr), exp);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();

    //            rs tu rt tu ewa et mwa mt stall
    vecs[0] = '{5, 0, 0, 3, 5, 2, 0, 0, 1};  // load-use via E
    vecs[1] = '{5, 0, 0, 3, 0, 0, 5, 1, 1};  // still waiting in M
    vecs[2] = '{5, 0, 0, 3, 0, 0, 5, 0, 0};  // now forwardable from M
    vecs[3] = '{0, 3, 8, 1, 8, 1, 0, 0, 0};  // rt forwardable
    vecs[4] = '{0, 0, 0, 3, 0, 2, 0, 0, 0};  // register 0 exempt
    vecs[5] = '{0, 3, 8, 1, 8, 2, 0, 0, 1};  // rt too early
    vecs[6] = '{5, 3, 0, 3, 5, 2, 0, 0, 0};  // rs unused
    vecs[7] = '{0, 3, 9, 0, 9, 0, 9, 1, 1};  // M term stalls though E is ready
    vecs[8] = '{4, 2, 0, 3, 4, 2, 0, 0, 0};  // tnew equal to tuse
    vecs[9] = '{3, 0, 3, 0, 3, 1, 0, 0, 1};  // both sources hit

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bif.md_busy), 0);
    chk("rst_err",  int'(bif.md_err), 0);
    chk("rst_cnt",  int'(bif.stall_cnt), 0);
    reset = 1'b1;

    // Combinational hazard table.
    foreach (vecs[i]) begin
      @(negedge clk);
      bif.d_rs_addr = 5'(vecs[i].rs);
      bif.d_rs_tuse = 2'(vecs[i].rs_tuse);
      bif.d_rt_addr = 5'(vecs[i].rt);
      bif.d_rt_tuse = 2'(vecs[i].rt_tuse);
      bif.e_wa      = 5'(vecs[i].ewa);
      bif.e_tnew    = 2'(vecs[i].etnew);
      bif.m_wa      = 5'(vecs[i].mwa);
      bif.m_tnew    = 2'(vecs[i].mtnew);
      #1;
      chk_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
    end

    // Mult with a dependent MD op waiting in D.
    idle_inputs();
    do_reset();
    bif.d_md_op    = 1'b1;
    bif.e_md_start = 2'b01;
    #1;
    chk_stall("mul_issue", 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bif.e_md_start = 2'b00;
      #1;
      chk($sformatf("mul_busy%0d", i), int'(bif.md_busy), 1);
      chk($sformatf("mul_block%0d", i), int'(bif.block), 1);
    end
    @(negedge clk);
    #1;
    chk("mul_done_busy",  int'(bif.md_busy), 0);
    chk("mul_done_block", int'(bif.block), 0);
    chk("mul_cnt",        int'(bif.stall_cnt), 6);

    // Div interrupted by reset.
    idle_inputs();
    @(negedge clk);
    bif.e_md_start = 2'b10;
    @(negedge clk);
    bif.e_md_start = 2'b00;
    repeat (2) @(negedge clk);
    chk("div_busy_pre", int'(bif.md_busy), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("div_rst_busy", int'(bif.md_busy), 0);
    chk("div_rst_cnt",  int'(bif.stall_cnt), 0);
    chk("div_rst_err",  int'(bif.md_err), 0);
    reset = 1'b1;

    // Start during a div is dropped and flagged; div still runs 10 cycles.
    @(negedge clk);
    bif.e_md_start = 2'b10;
    @(negedge clk);
    bif.e_md_start = 2'b01;
    @(negedge clk);
    bif.e_md_start = 2'b00;
    chk("ill_err", int'(bif.md_err), 1);
    for (int i = 2; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("ill_div_busy%0d", i), int'(bif.md_busy), 1);
    end
    @(negedge clk);
    chk("ill_div_done", int'(bif.md_busy), 0);

    // Illegal code in IDLE leaves the tracker idle.
    do_reset();
    chk("bad_pre_err", int'(bif.md_err), 0);
    bif.e_md_start = 2'b11;
    @(negedge clk);
    bif.e_md_start = 2'b00;
    chk("bad_err",  int'(bif.md_err), 1);
    chk("bad_busy", int'(bif.md_busy), 0);
    @(negedge clk);
    chk("bad_err_sticky", int'(bif.md_err), 1);
    chk("bad_busy2",      int'(bif.md_busy), 0);

    // Counter saturation, then clear beating a simultaneous stall.
    do_reset();
    bif.d_rs_addr = 5'd5;
    bif.d_rs_tuse = 2'd0;
    bif.e_wa      = 5'd5;
    bif.e_tnew    = 2'd2;
    repeat (70000) @(negedge clk);
    chk("sat_cnt", int'(bif.stall_cnt), 65535);
    bif.cnt_clr = 1'b1;
    #1;
    chk("clr_stall", int'(bif.block), 1);
    @(negedge clk);
    chk("clr_cnt", int'(bif.stall_cnt), 0);
    bif.cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_resume", int'(bif.stall_cnt), 1);

    // Randomized traffic against the model.
    idle_inputs();
    do_reset();
    m_busy_left = 0;
    m_err       = 0;
    m_cnt       = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(negedge clk);
      bif.d_rs_addr = 5'($urandom_range(0, 3));
      bif.d_rt_addr = 5'($urandom_range(0, 3));
      bif.d_rs_tuse = 2'($urandom_range(0, 3));
      bif.d_rt_tuse = 2'($urandom_range(0, 3));
      bif.e_wa      = 5'($urandom_range(0, 3));
      bif.m_wa      = 5'($urandom_range(0, 3));
      bif.e_tnew    = 2'($urandom_range(0, 2));
      bif.m_tnew    = 2'($urandom_range(0, 2));
      bif.d_md_op   = 1'($urandom_range(0, 1));
      bif.cnt_clr   = ($urandom_range(0, 31) == 0);
      reset         = ($urandom_range(0, 127) != 0);
      r = int'($urandom_range(0, 255));
      if (r < 12)       bif.e_md_start = 2'b01;
      else if (r < 20)  bif.e_md_start = 2'b10;
      else if (r == 255) bif.e_md_start = 2'b11;
      else              bif.e_md_start = 2'b00;
      #1;
      chk("rnd_block",   int'(bif.block),     model_stall());
      chk("rnd_fd_en",   int'(bif.fd_en),     1 - model_stall());
      chk("rnd_de_clr",  int'(bif.de_clr),    model_stall());
      chk("rnd_busy",    int'(bif.md_busy),   (m_busy_left > 0) ? 1 : 0);
      chk("rnd_err",     int'(bif.md_err),    m_err);
      chk("rnd_cnt",     int'(bif.stall_cnt), m_cnt);
      @(posedge clk);
      model_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
